// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, data-length decode, line levels.
// UART_TX_BREAK_EN adds the BREAK state.
package uart_pkg;

  localparam logic MARK  = 1'b1;
  localparam logic SPACE = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP_0 = 3'd4,
    STOP_1 = 3'd5
`ifdef UART_TX_BREAK_EN
    ,
    BREAK  = 3'd6
`endif
  } tx_state_e;

  // Frame data-bit count from the register code; anything unrecognised means 5.
  function automatic logic [3:0] data_len(input logic [3:0] code);
    case (code)
      4'd6:    data_len = 4'd6;
      4'd7:    data_len = 4'd7;
      4'd8:    data_len = 4'd8;
      default: data_len = 4'd5;
    endcase
  endfunction

endpackage

// File: rtl/tx_shift_register.sv
// TX datapath: word load, LSB-first shift, sent-bit counter and running parity.
module tx_shift_register #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_bit0,
  output logic              o_bit1,
  output logic [CNT_W-1:0]  o_cnt,
  output logic              o_par_nxt
);

  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_cnt   <= '0;
      r_par   <= 1'b0;
    end else if (i_shift) begin
      r_shift <= {1'b0, r_shift[DATA_W-1:1]};
      r_par   <= r_par ^ r_shift[0];
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign o_bit0    = r_shift[0];
  assign o_bit1    = r_shift[1];
  assign o_cnt     = r_cnt;
  // Parity including the bit currently on the line.
  assign o_par_nxt = r_par ^ r_shift[0];

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit FSM: pops FIFO words and serialises start/data/parity/stop bits.
// Optional UART_TX_BREAK_EN adds a tx_break input and BREAK state.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              baud_tick,
  input  logic              TXen,
  input  logic [3:0]        number_data_transmit,
  input  logic              parity_bit_mode,
  input  logic              parity_odd,
  input  logic              stop_bit_twice,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_data_valid,
`ifdef UART_TX_BREAK_EN
  input  logic              tx_break,
`endif
  output logic              ctrl_tx_buffer,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  tx_state_e        r_state, w_nxt;
  logic             r_tx_out, w_tx_nxt;
  logic             r_armed;
  logic [CNT_W-1:0] r_len;
  logic             r_par_en, r_par_odd, r_stop2;
  logic             w_tick, w_can_pop, w_pop, w_done, w_shift, w_eof, w_last;
  logic             w_bit0, w_bit1, w_par_nxt;
  logic [CNT_W-1:0] w_cnt;
`ifdef UART_TX_BREAK_EN
  logic             r_brk;
`endif

  tx_shift_register #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_shift (
    .clk      (PCLK),
    .rst      (PRESET),
    .i_load   (w_pop),
    .i_shift  (w_shift),
    .i_data   (tx_data),
    .o_bit0   (w_bit0),
    .o_bit1   (w_bit1),
    .o_cnt    (w_cnt),
    .o_par_nxt(w_par_nxt)
  );

  // r_armed masks a tick landing on the first edge after reset release.
  assign w_tick    = baud_tick & r_armed;
  assign w_can_pop = TXen & tx_data_valid;
  assign w_last    = (w_cnt + CNT_W'(1)) == r_len;

  always_comb begin
    w_nxt    = r_state;
    w_tx_nxt = r_tx_out;
    w_pop    = 1'b0;
    w_shift  = 1'b0;
    w_eof    = 1'b0;
    if (w_tick) begin
      case (r_state)
        IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (tx_break) begin
            w_nxt    = BREAK;
            w_tx_nxt = SPACE;
          end else
`endif
          if (w_can_pop) begin
            w_pop    = 1'b1;
            w_nxt    = START;
            w_tx_nxt = SPACE;
          end
        end
        START: begin
          w_nxt    = DATA;
          w_tx_nxt = w_bit0;
        end
        DATA: begin
          w_shift = 1'b1;
          if (!w_last) begin
            w_tx_nxt = w_bit1;
          end else if (r_par_en) begin
            w_nxt    = PARITY;
            w_tx_nxt = w_par_nxt ^ r_par_odd;
          end else begin
            w_nxt    = STOP_0;
            w_tx_nxt = MARK;
          end
        end
        PARITY: begin
          w_nxt    = STOP_0;
          w_tx_nxt = MARK;
        end
        STOP_0: begin
          if (r_stop2) begin
            w_nxt    = STOP_1;
            w_tx_nxt = MARK;
          end else begin
            w_eof = 1'b1;
          end
        end
        STOP_1: w_eof = 1'b1;
`ifdef UART_TX_BREAK_EN
        BREAK: begin
          if (!tx_break) begin
            w_nxt    = STOP_0;
            w_tx_nxt = MARK;
          end
        end
`endif
        default: begin
          w_nxt    = IDLE;
          w_tx_nxt = MARK;
        end
      endcase
    end
    // End of frame chains straight into the next start bit when a word waits.
    if (w_eof) begin
      if (w_can_pop) begin
        w_pop    = 1'b1;
        w_nxt    = START;
        w_tx_nxt = SPACE;
      end else begin
        w_nxt    = IDLE;
        w_tx_nxt = MARK;
      end
    end
  end

`ifdef UART_TX_BREAK_EN
  assign w_done = w_eof & ~r_brk;
`else
  assign w_done = w_eof;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state   <= IDLE;
      r_tx_out  <= MARK;
      r_armed   <= 1'b0;
      r_len     <= CNT_W'(5);
      r_par_en  <= 1'b0;
      r_par_odd <= 1'b0;
      r_stop2   <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_tx_out <= w_tx_nxt;
      r_armed  <= 1'b1;
      if (w_pop) begin
        r_len     <= CNT_W'(data_len(number_data_transmit));
        r_par_en  <= parity_bit_mode;
        r_par_odd <= parity_odd;
        r_stop2   <= stop_bit_twice;
      end
    end
  end

`ifdef UART_TX_BREAK_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)                                r_brk <= 1'b0;
    else if (w_tick && r_state == IDLE && tx_break) r_brk <= 1'b1;
    else if (w_eof)                            r_brk <= 1'b0;
  end
`endif

  assign ctrl_tx_buffer = w_pop;
  assign tx_done        = w_done;
  assign tx_out         = r_tx_out;
  assign tx_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm: frame formats, back-to-back, TXen drop, reset.
module tb_uart_tx_fsm;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       baud_tick = 1'b0;
  logic       TXen = 1'b0;
  logic [3:0] number_data_transmit = 4'd8;
  logic       parity_bit_mode = 1'b0;
  logic       parity_odd = 1'b0;
  logic       stop_bit_twice = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_data_valid = 1'b0;
  logic       tx_break = 1'b0;
  logic       ctrl_tx_buffer, tx_out, tx_busy, tx_done;

  int checks = 0;
  int failures = 0;
  logic [7:0] fifo[$];

  uart_tx_fsm #(.DATA_W(8), .CNT_W(4)) dut (
    .PCLK                (PCLK),
    .PRESET              (PRESET),
    .baud_tick           (baud_tick),
    .TXen                (TXen),
    .number_data_transmit(number_data_transmit),
    .parity_bit_mode     (parity_bit_mode),
    .parity_odd          (parity_odd),
    .stop_bit_twice      (stop_bit_twice),
    .tx_data             (tx_data),
    .tx_data_valid       (tx_data_valid),
`ifdef UART_TX_BREAK_EN
    .tx_break            (tx_break),
`endif
    .ctrl_tx_buffer      (ctrl_tx_buffer),
    .tx_out              (tx_out),
    .tx_busy             (tx_busy),
    .tx_done             (tx_done)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input logic obs, input logic exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    tx_data_valid = (fifo.size() > 0);
    tx_data       = (fifo.size() > 0) ? fifo[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] d);
    fifo.push_back(d);
    refresh();
  endtask

  task automatic cfg(input logic [3:0] n, input logic pen, input logic podd, input logic s2);
    number_data_transmit = n;
    parity_bit_mode      = pen;
    parity_odd           = podd;
    stop_bit_twice       = s2;
  endtask

  // One baud tick: pop/done checked during the tick cycle, line/busy after it.
  task automatic tick(input logic ep, input logic ed, input logic el, input logic eb,
                      input string tag);
    logic popped;
    @(negedge PCLK);
    baud_tick = 1'b1;
    #1;
    chk(ctrl_tx_buffer, ep, {tag, ".pop"});
    chk(tx_done, ed, {tag, ".done"});
    popped = ctrl_tx_buffer;
    @(posedge PCLK);
    #1;
    baud_tick = 1'b0;
    if (popped && fifo.size() > 0) void'(fifo.pop_front());
    refresh();
    chk(tx_out, el, {tag, ".line"});
    chk(tx_busy, eb, {tag, ".busy"});
    repeat (2) @(posedge PCLK);
  endtask

  // bits[i] is the line level after tick i; a final end-of-frame tick follows.
  task automatic run_frame(input logic [15:0] bits, input int n, input logic popfirst,
                           input logic np, input logic nl, input string tag);
    if (popfirst) tick(1'b1, 1'b0, bits[0], 1'b1, $sformatf("%s.b0", tag));
    for (int i = 1; i < n; i++)
      tick(1'b0, 1'b0, bits[i], 1'b1, $sformatf("%s.b%0d", tag, i));
    tick(np, 1'b1, nl, np, $sformatf("%s.end", tag));
  endtask

  initial begin
    repeat (3) @(posedge PCLK);
    #1;
    chk(tx_out, 1'b1, "rst.line");
    chk(tx_busy, 1'b0, "rst.busy");
    chk(tx_done, 1'b0, "rst.done");
    chk(ctrl_tx_buffer, 1'b0, "rst.pop");
    @(negedge PCLK);
    PRESET = 1'b0;
    repeat (2) @(posedge PCLK);

    // FIFO empty: line idle, no pop
    TXen = 1'b1;
    tick(1'b0, 1'b0, 1'b1, 1'b0, "empty");

    // 8N1, A5
    cfg(4'd8, 1'b0, 1'b0, 1'b0);
    push(8'hA5);
    run_frame({1'b1, 8'hA5, 1'b0}, 10, 1'b1, 1'b0, 1'b1, "8n1");

    // 5E2, FF: five ones, even parity 1, two stops
    cfg(4'd3, 1'b1, 1'b0, 1'b1);
    push(8'hFF);
    run_frame({1'b1, 1'b1, 1'b1, 5'h1F, 1'b0}, 9, 1'b1, 1'b0, 1'b1, "5e2");

    // 7O1, 41, with config scrambled after the pop (must be ignored)
    cfg(4'd7, 1'b1, 1'b1, 1'b0);
    push(8'h41);
    tick(1'b1, 1'b0, 1'b0, 1'b1, "7o1.b0");
    cfg(4'd8, 1'b0, 1'b0, 1'b1);
    run_frame({1'b1, 1'b1, 7'h41, 1'b0}, 10, 1'b0, 1'b0, 1'b1, "7o1");

    // back-to-back 00 then FF, 8N1
    cfg(4'd8, 1'b0, 1'b0, 1'b0);
    push(8'h00);
    push(8'hFF);
    run_frame({1'b1, 8'h00, 1'b0}, 10, 1'b1, 1'b1, 1'b0, "b2b0");
    run_frame({1'b1, 8'hFF, 1'b0}, 10, 1'b0, 1'b0, 1'b1, "b2b1");

    // TXen dropped during data bit 3: frame completes, next word stays queued
    push(8'h55);
    push(8'h0F);
    tick(1'b1, 1'b0, 1'b0, 1'b1, "txen.b0");
    for (int i = 1; i < 10; i++) begin
      if (i == 4) TXen = 1'b0;
      tick(1'b0, 1'b0, (i == 9) ? 1'b1 : ((i % 2) == 1), 1'b1, $sformatf("txen.b%0d", i));
    end
    tick(1'b0, 1'b1, 1'b1, 1'b0, "txen.end");
    tick(1'b0, 1'b0, 1'b1, 1'b0, "txen.idle");

    // reset during DATA, then release coinciding with a tick
    TXen = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b1, "rst2.b0");
    tick(1'b0, 1'b0, 1'b1, 1'b1, "rst2.b1");
    tick(1'b0, 1'b0, 1'b1, 1'b1, "rst2.b2");
    @(negedge PCLK);
    PRESET = 1'b1;
    #1;
    chk(tx_out, 1'b1, "rst2.async_line");
    chk(tx_busy, 1'b0, "rst2.async_busy");
    push(8'hA5);
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
    baud_tick = 1'b1;
    #1;
    chk(ctrl_tx_buffer, 1'b0, "rst2.rel_pop");
    @(posedge PCLK);
    #1;
    baud_tick = 1'b0;
    chk(tx_out, 1'b1, "rst2.rel_line");
    chk(tx_busy, 1'b0, "rst2.rel_busy");
    repeat (2) @(posedge PCLK);
    run_frame({1'b1, 8'hA5, 1'b0}, 10, 1'b1, 1'b0, 1'b1, "fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fsm.md
Name: uart_tx_fsm

Overview:
- UART transmit engine: the other end of the RX FSM's frame format.
- Pops one word from the TX FIFO and serialises it LSB-first as: start bit (0), 5–8 data bits, optional parity, then 1 or 2 stop bits (1).
- Sits between the APB register/FIFO side and the TXD pin. Bit timing comes from the shared baud generator's single-cycle baud_tick enable.

Parameters:
- DATA_W, 8, width of the FIFO data word; maximum frame data bits.
- CNT_W, 4, width of the internal data-bit counter.

Ports:
- PCLK  input  1  system clock; all state changes occur on the rising edge.
- PRESET  input  1  reset, asynchronous, active-high.
- baud_tick  input  1  one-PCLK-cycle pulse per bit period.
- TXen  input  1  transmitter enable.
- number_data_transmit  input  4  data bits per frame (6, 7 or 8; any other value means 5).
- parity_bit_mode  input  1  parity bit enabled.
- parity_odd  input  1  1 = odd parity, 0 = even parity.
- stop_bit_twice  input  1  1 = two stop bits.
- tx_data  input  DATA_W  FIFO head word.
- tx_data_valid  input  1  FIFO not empty.
- ctrl_tx_buffer  output  1  one-cycle FIFO pop strobe.
- tx_out  output  1  serial line.
- tx_busy  output  1  frame in progress.
- tx_done  output  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset values: tx_out=1, tx_busy=0, tx_done=0, ctrl_tx_buffer=0, state=IDLE, shift register=0, bit counter=0.
- Reset asserted mid-frame: tx_out returns to 1 immediately (asynchronous). The partial frame is abandoned and the word is not re-popped.
- Every state transition is qualified by baud_tick=1. There is one bit period per state visit, except DATA, which is visited N times.
- States: IDLE, START, DATA, PARITY, STOP_0, STOP_1. The state enum is 3 bits.
- IDLE → START: requires baud_tick & TXen & tx_data_valid.
  - ctrl_tx_buffer=1 for exactly that PCLK cycle.
  - tx_data is latched into the shift register.
  - number_data_transmit, parity_bit_mode, parity_odd and stop_bit_twice are latched into shadow registers; mid-frame config changes are ignored.
  - Parity accumulator is cleared.
- START: tx_out=0. On baud_tick → DATA; tx_out = shift[0].
- DATA: on each baud_tick, shift right, fold the outgoing bit into parity, and increment the counter.
  - After bit N (N = 5..8), go to PARITY if parity is enabled, else STOP_0.
  - Word bits at index ≥ N are neither sent nor included in parity.
- PARITY: tx_out = XOR of the N data bits, XOR parity_odd. On baud_tick → STOP_0.
- STOP_0: tx_out=1. On baud_tick:
  - stop_bit_twice=1: go to STOP_1.
  - otherwise: end of frame.
- STOP_1: tx_out=1. On baud_tick: end of frame.
- End of frame:
  - tx_done=1 for that single cycle.
  - If TXen & tx_data_valid, go directly to START with a pop in the same cycle (back-to-back, no idle bit). Otherwise go to IDLE.
- tx_busy=1 in every state except IDLE.
- Latency: pop-to-start-bit on the line is 1 PCLK cycle (registered tx_out). A frame lasts 1+N+P+S baud periods.
- TXen deasserted mid-frame: the current frame completes normally. No new pop occurs; the FSM then stays in IDLE.
- tx_data_valid=0 in IDLE: line held at 1, no pop.
- baud_tick coinciding with reset release: ignored; the first transition uses the next tick.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- With the macro:
  - Adds input port tx_break and state BREAK.
  - IDLE with tx_break=1 on baud_tick → BREAK, which has priority over a pop.
  - BREAK drives tx_out=0 until a baud_tick with tx_break=0, then goes to STOP_0 (one mark bit).
  - tx_done is not pulsed after a break; tx_busy=1 during BREAK.
- Without the macro: no port, no state; behaviour exactly as above.

Decomposition:
- Package uart_pkg holds:
  - tx_state_e enum;
  - data-length decode function (4-bit code → 5..8), shared with the RX FSM;
  - the line constants MARK=1'b1 and SPACE=1'b0.
- One sub-module, tx_shift_register: load, shift-on-enable, bit counter, running parity.
- The FSM stays in uart_tx_fsm.

Test Plan:
- 8N1, tx_data=8'hA5, one word in FIFO → tx_out over 10 ticks = 0,1,0,1,0,0,1,0,1,1; one pop; one tx_done pulse; tx_busy high for 10 bit periods.
- 5E2 (code 4'd3), tx_data=8'hFF → 0,1,1,1,1,1,1,1,1 (parity=1); line = 9 bits; bits 5..7 not sent.
- 7O1, tx_data=8'h41 → 0,1,0,0,0,0,0,1,1,1 (odd parity bit=1).
- Two words 8'h00 and 8'hFF queued, 8N1 → 20 consecutive bit periods, no idle gap; pops on ticks 0 and 10; two tx_done pulses.
- TXen dropped during DATA bit 3 → frame completes, including stop; next word not popped; tx_out stays 1.
- PRESET pulsed during DATA → tx_out=1 and tx_busy=0 immediately; after release, the next baud_tick with data valid starts a fresh frame.
